channel_ctrl: RTL and testbench

- Per-channel digital sequencer for one pixel analog channel (CSA, discriminator, async SAR ADC).
- Arms the CSA, detects discriminator hits or external triggers, and sequences sample/strobe.
- Waits for ADC done, captures the ADC word plus a timestamp into a one-entry output buffer, then resets the CSA and re-arms.
- Sits between the analog channel and the chip event router, which drains events via a valid/ready handshake.

---
 rtl/channel_ctrl_pkg.sv | 26 ++
 rtl/channel_ctrl_sync2.sv | 26 ++
 rtl/channel_ctrl.sv | 150 +++++++++++++++
 tb/tb_channel_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_ctrl_pkg.sv
// channel_ctrl_pkg: shared types and constants for the pixel channel sequencer
package channel_ctrl_pkg;

   localparam int EV_ADC_W = 10;
   localparam int EV_TS_W  = 24;

   localparam logic TRIG_EXT = 1'b0;
   localparam logic TRIG_HIT = 1'b1;

   typedef enum logic [2:0] {
      CSA_RST,
      ARMED,
      HOLD,
      SAMPLE,
      CONVERT,
      CAPTURE
   } ctrl_state_t;

   typedef struct packed {
      logic                trig_type;
      logic                conv_err;
      logic [EV_TS_W-1:0]  timestamp;
      logic [EV_ADC_W-1:0] adc_word;
   } event_t;

endpackage

// File: rtl/channel_ctrl_sync2.sv
// sync2: two-flop synchronizer for asynchronous analog-side flags
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/channel_ctrl.sv
// channel_ctrl: per-channel sequencer arming the CSA, sequencing sample/strobe,
// and buffering one {trig_type, conv_err, timestamp, adc_word} event.
module channel_ctrl
   import channel_ctrl_pkg::*;
#(
   parameter int ADCBITS      = EV_ADC_W,
   parameter int TS_BITS      = EV_TS_W,
   parameter int CNT_BITS     = 8,
   parameter int CONV_TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      hit,
   input  logic                      external_trigger,
   input  logic                      done,
   input  logic [ADCBITS-1:0]        dout,
   input  logic [CNT_BITS-1:0]       hold_delay,
   input  logic [CNT_BITS-1:0]       sample_cycles,
   input  logic [CNT_BITS-1:0]       reset_cycles,
   output logic                      sample,
   output logic                      strobe,
   output logic                      csa_reset,
   output logic                      event_valid,
   output logic [ADCBITS+TS_BITS+1:0] event_data,
   input  logic                      event_ready,
   output logic                      overflow,
   output logic                      busy
);

   localparam int TW = $clog2(CONV_TIMEOUT + 1);
   localparam int CW = (CNT_BITS > TW) ? CNT_BITS : TW;

   ctrl_state_t          r_state;
   ctrl_state_t          w_next;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_load;
   logic [TS_BITS-1:0]   r_ts;
   logic [TS_BITS-1:0]   r_ts_lat;
   logic [ADCBITS-1:0]   r_adc;
   logic                 r_trig;
   logic                 r_err;
   logic                 r_hit_d;
   logic                 r_hit_rise;
   logic                 r_valid;
   logic                 r_ovf;
   event_t               r_event;
   logic                 w_hit_s;
   logic                 w_done_s;
   logic                 w_accept;
   logic                 w_cnt_zero;

   // Durations count down from max(x,1)-1 so a zero setting still lasts one cycle.
   function automatic logic [CW-1:0] len(input logic [CNT_BITS-1:0] x);
      return (x == '0) ? '0 : CW'(x) - CW'(1);
   endfunction

   sync2 #(.W(1)) u_sync_hit (
      .clk   (clk),
      .reset (reset),
      .i_d   (hit),
      .o_q   (w_hit_s)
   );

   sync2 #(.W(1)) u_sync_done (
      .clk   (clk),
      .reset (reset),
      .i_d   (done),
      .o_q   (w_done_s)
   );

   assign w_accept   = enable & (r_hit_rise | external_trigger);
   assign w_cnt_zero = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= CSA_RST;
         r_cnt   <= len(reset_cycles);
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next != r_state) ? w_load : r_cnt - CW'(1);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         CSA_RST: w_next = w_cnt_zero ? ARMED : CSA_RST;
         ARMED:   w_next = !w_accept ? ARMED : (hold_delay == '0) ? SAMPLE : HOLD;
         HOLD:    w_next = w_cnt_zero ? SAMPLE : HOLD;
         SAMPLE:  w_next = w_cnt_zero ? CONVERT : SAMPLE;
         CONVERT: w_next = (w_done_s || w_cnt_zero) ? CAPTURE : CONVERT;
         default: w_next = CSA_RST;
      endcase
   end

   always_comb begin
      w_load = (w_next == CSA_RST) ? len(reset_cycles) :
               (w_next == HOLD)    ? len(hold_delay) :
               (w_next == SAMPLE)  ? len(sample_cycles) :
               (w_next == CONVERT) ? CW'(CONV_TIMEOUT - 1) : '0;
   end

   always_comb begin
      sample    = (r_state == SAMPLE);
      csa_reset = (r_state == CSA_RST);
      busy      = (r_state != ARMED);
      strobe    = (r_state == CONVERT) && (r_cnt == CW'(CONV_TIMEOUT - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ts       <= '0;
         r_ts_lat   <= '0;
         r_hit_d    <= 1'b0;
         r_hit_rise <= 1'b0;
         r_trig     <= TRIG_EXT;
         r_adc      <= '0;
         r_err      <= 1'b0;
         r_event    <= '0;
         r_valid    <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_ts       <= r_ts + TS_BITS'(1);
         r_hit_d    <= w_hit_s;
         r_hit_rise <= w_hit_s & ~r_hit_d;
         if (r_state == ARMED && w_accept) begin
            r_trig   <= r_hit_rise ? TRIG_HIT : TRIG_EXT;
            r_ts_lat <= r_ts;
         end
         // The last CONVERT cycle decides: done wins, otherwise the timeout leaves a zero word.
         if (r_state == CONVERT) begin
            r_adc <= w_done_s ? dout : '0;
            r_err <= ~w_done_s;
         end
         if (r_state == CAPTURE && (!r_valid || event_ready)) begin
            r_event <= {r_trig, r_err, r_ts_lat, r_adc};
            r_valid <= 1'b1;
         end else begin
            if (r_valid && event_ready) r_valid <= 1'b0;
            if (r_state == CAPTURE) r_ovf <= 1'b1;
         end
      end
   end

   assign event_valid = r_valid;
   assign event_data  = r_event;
   assign overflow    = r_ovf;

endmodule

// File: tb/tb_channel_ctrl.sv
// tb_channel_ctrl: directed self-checking bench for channel_ctrl with
// hand-computed latencies and event words.
module tb_channel_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic        hit = 1'b0;
   logic        external_trigger = 1'b0;
   logic        done = 1'b0;
   logic        event_ready = 1'b0;
   logic [9:0]  dout = '0;
   logic [7:0]  hold_delay = 8'd3;
   logic [7:0]  sample_cycles = 8'd5;
   logic [7:0]  reset_cycles = 8'd4;
   logic        sample, strobe, csa_reset, event_valid, overflow, busy;
   logic [35:0] event_data;
   logic [35:0] held;
   logic [23:0] tb_ts = '0;
   logic [23:0] exp_ts;
   int          checks = 0;
   int          errors = 0;
   int          k;

   channel_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .hit              (hit),
      .external_trigger (external_trigger),
      .done             (done),
      .dout             (dout),
      .hold_delay       (hold_delay),
      .sample_cycles    (sample_cycles),
      .reset_cycles     (reset_cycles),
      .sample           (sample),
      .strobe           (strobe),
      .csa_reset        (csa_reset),
      .event_valid      (event_valid),
      .event_data       (event_data),
      .event_ready      (event_ready),
      .overflow         (overflow),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   // Reference free-running timestamp: zero under reset, +1 per clock.
   always @(posedge clk) tb_ts <= reset ? 24'd0 : tb_ts + 24'd1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_armed(input string tag);
      k = 0;
      while (busy && k < 200) begin
         tick();
         k++;
      end
      chk(tag, busy, 0);
   endtask

   task automatic wait_valid(input string tag);
      k = 0;
      while (!event_valid && k < 200) begin
         tick();
         k++;
      end
      chk(tag, event_valid, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      chk("rst_csa", csa_reset, 1);
      chk("rst_busy", busy, 1);
      chk("rst_sample", sample, 0);
      chk("rst_strobe", strobe, 0);
      chk("rst_valid", event_valid, 0);
      chk("rst_data", event_data, 0);
      chk("rst_ovf", overflow, 0);
      reset = 1'b0;
      k = 0;
      while (csa_reset && k < 20) begin
         k++;
         tick();
      end
      chk("rst_len", k, 4);
      chk("armed_busy", busy, 0);
      chk("armed_sample", sample, 0);
      chk("armed_valid", event_valid, 0);

      // hit, hold 3, sample 5: strobe 2+1+3+5 = 11 cycles after hit is first sampled
      hit = 1'b1;
      k = 0;
      while (!strobe && k < 40) begin
         tick();
         k++;
         if (k == 3) exp_ts = tb_ts;
      end
      chk("hit_latency", k - 1, 11);
      hit = 1'b0;
      tick();
      chk("strobe_width", strobe, 0);
      repeat (9) tick();
      dout = 10'h2A5;
      done = 1'b1;
      wait_valid("hit_ev_wait");
      chk("hit_ev_data", event_data, {1'b1, 1'b0, exp_ts, 10'h2A5});
      chk("hit_ev_ovf", overflow, 0);
      done = 1'b0;
      event_ready = 1'b1;
      tick();
      event_ready = 1'b0;
      chk("drain1", event_valid, 0);
      wait_armed("armed2");

      // external trigger with no done: timeout after 64 CONVERT cycles; hit in CONVERT ignored
      exp_ts = tb_ts;
      external_trigger = 1'b1;
      tick();
      external_trigger = 1'b0;
      k = 0;
      while (!strobe && k < 40) begin
         tick();
         k++;
      end
      chk("ext_strobe_seen", strobe, 1);
      k = 0;
      while (!event_valid && k < 200) begin
         tick();
         k++;
         if (k == 5) hit = 1'b1;
         if (k == 8) hit = 1'b0;
      end
      chk("timeout_latency", k, 65);
      chk("timeout_data", event_data, {1'b0, 1'b1, exp_ts, 10'h000});
      held = event_data;
      wait_armed("armed3");
      repeat (30) tick();
      chk("no_extra_ovf", overflow, 0);
      chk("no_extra_data", event_data, held);

      // second event while buffer is full, hold_delay=0 path
      hold_delay = 8'd0;
      dout = 10'h155;
      done = 1'b1;
      external_trigger = 1'b1;
      k = 0;
      while (!strobe && k < 40) begin
         tick();
         k++;
         if (k == 1) external_trigger = 1'b0;
      end
      chk("hd0_latency", k, 6);
      k = 0;
      while (!overflow && k < 50) begin
         tick();
         k++;
      end
      chk("ovf_set", overflow, 1);
      chk("ovf_valid", event_valid, 1);
      chk("ovf_retain", event_data, held);
      done = 1'b0;
      event_ready = 1'b1;
      tick();
      event_ready = 1'b0;
      chk("drain2", event_valid, 0);
      chk("ovf_sticky", overflow, 1);
      wait_armed("armed4");

      // hit and external trigger together; sample_cycles=0 acts as 1
      hold_delay = 8'd3;
      sample_cycles = 8'd0;
      dout = 10'h3C3;
      done = 1'b1;
      hit = 1'b1;
      k = 0;
      while (!strobe && k < 40) begin
         tick();
         k++;
         if (k == 3) begin
            external_trigger = 1'b1;
            exp_ts = tb_ts;
         end
         if (k == 4) external_trigger = 1'b0;
      end
      chk("both_latency", k - 1, 7);
      hit = 1'b0;
      wait_valid("both_wait");
      chk("both_data", event_data, {1'b1, 1'b0, exp_ts, 10'h3C3});
      done = 1'b0;
      event_ready = 1'b1;
      tick();
      event_ready = 1'b0;
      wait_armed("armed5");
      repeat (10) tick();
      chk("both_single", event_valid, 0);

      // channel disabled: triggers ignored
      enable = 1'b0;
      repeat (3) begin
         hit = 1'b1;
         repeat (3) tick();
         hit = 1'b0;
         external_trigger = 1'b1;
         tick();
         external_trigger = 1'b0;
         repeat (3) tick();
         chk("dis_busy", busy, 0);
      end
      chk("dis_valid", event_valid, 0);
      enable = 1'b1;
      repeat (3) tick();
      chk("reen_busy", busy, 0);

      // pending event then reset during SAMPLE
      sample_cycles = 8'd5;
      dout = 10'h0AA;
      done = 1'b1;
      exp_ts = tb_ts;
      external_trigger = 1'b1;
      tick();
      external_trigger = 1'b0;
      wait_valid("pre_rst_wait");
      chk("pre_rst_data", event_data, {1'b0, 1'b0, exp_ts, 10'h0AA});
      done = 1'b0;
      wait_armed("armed6");
      external_trigger = 1'b1;
      tick();
      external_trigger = 1'b0;
      k = 0;
      while (!sample && k < 40) begin
         tick();
         k++;
      end
      chk("in_sample", sample, 1);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_sample", sample, 0);
      chk("mid_rst_csa", csa_reset, 1);
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_valid", event_valid, 0);
      chk("mid_rst_data", event_data, 0);
      chk("mid_rst_ovf", overflow, 0);
      reset = 1'b0;
      wait_armed("armed7");
      repeat (20) tick();
      chk("post_rst_valid", event_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
